// File: rtl/maze_solver_if.sv
//------------------------------------------------------------------------------
// Module : maze_solver_if
// Brief  : Path-cell stream handshake between the maze solver and its consumer
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface maze_solver_if;
  logic       step_valid;
  logic       step_ready;
  logic [3:0] step_x;
  logic [3:0] step_y;

  modport master (output step_valid, output step_x, output step_y, input step_ready);
  modport slave  (input step_valid, input step_x, input step_y, output step_ready);
endinterface

`default_nettype wire

// File: rtl/maze_solver.sv
//------------------------------------------------------------------------------
// Module : maze_solver
// Brief  : Left-hand wall-follower over a 16x16 maze bitmap, streaming the path
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module maze_solver #(
  parameter int MAZE_W    = 16,
  parameter int MAZE_H    = 16,
  parameter int MAX_STEPS = 1023
) (
  input  wire logic                      clk,
  input  wire logic                      reset,
  input  wire logic                      start,
  input  wire logic [MAZE_W*MAZE_H-1:0]  maze_data,
  input  wire logic [3:0]                goal_x,
  input  wire logic [3:0]                goal_y,
  maze_solver_if.master                  step,
  output logic      [9:0]                step_count,
  output logic                           done,
  output logic                           fail
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_EMIT  = 3'd2,
    S_PROBE = 3'd3,
    S_DONE  = 3'd4,
    S_FAIL  = 3'd5
  } state_t;

  localparam logic [1:0] c_dir_n = 2'd0;
  localparam logic [1:0] c_dir_e = 2'd1;
  localparam logic [1:0] c_dir_s = 2'd2;
  localparam logic [1:0] c_dir_w = 2'd3;
  localparam logic [3:0] c_x_max = 4'(MAZE_W - 1);
  localparam logic [3:0] c_y_max = 4'(MAZE_H - 1);
  localparam logic [9:0] c_max   = 10'(MAX_STEPS);

  state_t                     r_state;
  state_t                     w_state_next;
  logic [MAZE_W*MAZE_H-1:0]   r_maze;
  logic [3:0]                 r_goal_x;
  logic [3:0]                 r_goal_y;
  logic [3:0]                 r_cur_x;
  logic [3:0]                 r_cur_y;
  logic [1:0]                 r_heading;
  logic [1:0]                 r_probe;
  logic [9:0]                 r_step_count;

  logic [1:0]                 w_cand;
  logic [3:0]                 w_nx;
  logic [3:0]                 w_ny;
  logic                       w_inb;
  logic                       w_open;
  logic                       w_xfer;
  logic                       w_at_goal;
  logic [9:0]                 w_count_inc;

  // Probe offsets {3,0,1,2} for left/straight/right/back reduce to probe-1.
  assign w_cand      = r_heading + r_probe - 2'd1;
  assign w_xfer      = (r_state == S_EMIT) && step.step_ready;
  assign w_at_goal   = (r_cur_x == r_goal_x) && (r_cur_y == r_goal_y);
  assign w_count_inc = r_step_count + 10'd1;

  // Out-of-range neighbours are walls; coordinates never wrap.
  always_comb begin
    w_nx  = r_cur_x;
    w_ny  = r_cur_y;
    w_inb = 1'b0;
    case (w_cand)
      c_dir_n: begin w_inb = (r_cur_y != 4'd0);    w_ny = r_cur_y - 4'd1; end
      c_dir_e: begin w_inb = (r_cur_x != c_x_max); w_nx = r_cur_x + 4'd1; end
      c_dir_s: begin w_inb = (r_cur_y != c_y_max); w_ny = r_cur_y + 4'd1; end
      default: begin w_inb = (r_cur_x != 4'd0);    w_nx = r_cur_x - 4'd1; end
    endcase
    w_open = w_inb && r_maze[{w_ny, w_nx}];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = S_INIT;
      S_INIT:  begin
        if (!r_maze[0] || !r_maze[{r_goal_y, r_goal_x}]) w_state_next = S_FAIL;
        else                                             w_state_next = S_EMIT;
      end
      S_EMIT:  begin
        if (w_xfer) begin
          if (w_at_goal)                w_state_next = S_DONE;
          else if (w_count_inc == c_max) w_state_next = S_FAIL;
          else                          w_state_next = S_PROBE;
        end
      end
      S_PROBE: begin
        if (w_open)                w_state_next = S_EMIT;
        else if (r_probe == 2'd3)  w_state_next = S_FAIL;
      end
      S_DONE, S_FAIL: if (!start) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_maze       <= '0;
      r_goal_x     <= 4'd0;
      r_goal_y     <= 4'd0;
      r_cur_x      <= 4'd0;
      r_cur_y      <= 4'd0;
      r_heading    <= c_dir_e;
      r_probe      <= 2'd0;
      r_step_count <= 10'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_maze       <= maze_data;
            r_goal_x     <= goal_x;
            r_goal_y     <= goal_y;
            r_cur_x      <= 4'd0;
            r_cur_y      <= 4'd0;
            r_heading    <= c_dir_e;
            r_probe      <= 2'd0;
            r_step_count <= 10'd0;
          end
        end
        S_EMIT: begin
          if (w_xfer) begin
            r_step_count <= w_count_inc;
            r_probe      <= 2'd0;
          end
        end
        S_PROBE: begin
          if (w_open) begin
            r_cur_x   <= w_nx;
            r_cur_y   <= w_ny;
            r_heading <= w_cand;
          end else begin
            r_probe   <= r_probe + 2'd1;
          end
        end
        S_DONE, S_FAIL: if (!start) r_step_count <= 10'd0;
        default: ;
      endcase
    end
  end

  assign step.step_valid = (r_state == S_EMIT);
  assign step.step_x     = r_cur_x;
  assign step.step_y     = r_cur_y;
  assign step_count      = r_step_count;
  assign done            = (r_state == S_DONE);
  assign fail            = (r_state == S_FAIL);

endmodule

`default_nettype wire

// File: tb/tb_maze_solver.sv
//------------------------------------------------------------------------------
// Module : tb_maze_solver
// Brief  : Directed self-checking bench for maze_solver (MAX_STEPS set to 8)
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_maze_solver;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [255:0] maze_data;
  logic [3:0]   goal_x;
  logic [3:0]   goal_y;
  logic [9:0]   step_count;
  logic         done;
  logic         fail;
  int           errors = 0;
  int           checks = 0;

  maze_solver_if s_if ();

  maze_solver #(.MAZE_W(16), .MAZE_H(16), .MAX_STEPS(8)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .maze_data  (maze_data),
    .goal_x     (goal_x),
    .goal_y     (goal_y),
    .step       (s_if),
    .step_count (step_count),
    .done       (done),
    .fail       (fail)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for a valid step, checks it, and lets it transfer when ready=1.
  task automatic do_step(input logic [3:0] ex, input logic [3:0] ey, input logic [9:0] ec);
    int n = 0;
    while (s_if.step_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("step_valid", 32'(s_if.step_valid), 32'd1);
    chk("step_x", 32'(s_if.step_x), 32'(ex));
    chk("step_y", 32'(s_if.step_y), 32'(ey));
    chk("count_before", 32'(step_count), 32'(ec));
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; maze_data = '0; goal_x = 4'd0; goal_y = 4'd0;
    s_if.step_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(s_if.step_valid), 32'd0);
    chk("rst_x", 32'(s_if.step_x), 32'd0);
    chk("rst_y", 32'(s_if.step_y), 32'd0);
    chk("rst_count", 32'(step_count), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_fail", 32'(fail), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Straight corridor (0,0)..(3,0)
    maze_data = 256'hF; goal_x = 4'd3; goal_y = 4'd0; start = 1'b1;
    do_step(4'd0, 4'd0, 10'd0);
    do_step(4'd1, 4'd0, 10'd1);
    do_step(4'd2, 4'd0, 10'd2);
    do_step(4'd3, 4'd0, 10'd3);
    chk("cor_done", 32'(done), 32'd1);
    chk("cor_fail", 32'(fail), 32'd0);
    chk("cor_count", 32'(step_count), 32'd4);
    chk("cor_valid_off", 32'(s_if.step_valid), 32'd0);
    chk("cor_x_hold", 32'(s_if.step_x), 32'd3);
    start = 1'b0;
    @(negedge clk);
    chk("cor_idle_done", 32'(done), 32'd0);
    chk("cor_idle_count", 32'(step_count), 32'd0);

    // Backpressure on step 2
    start = 1'b1;
    do_step(4'd0, 4'd0, 10'd0);
    s_if.step_ready = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(s_if.step_valid), 32'd1);
      chk("bp_x", 32'(s_if.step_x), 32'd1);
      chk("bp_count", 32'(step_count), 32'd1);
      @(negedge clk);
    end
    s_if.step_ready = 1'b1;
    do_step(4'd1, 4'd0, 10'd1);
    do_step(4'd2, 4'd0, 10'd2);
    do_step(4'd3, 4'd0, 10'd3);
    chk("bp_done", 32'(done), 32'd1);
    chk("bp_count_end", 32'(step_count), 32'd4);
    start = 1'b0;
    @(negedge clk);

    // Dead-end backtrack: open (0,0),(1,0),(0,1),(0,2)
    maze_data = '0;
    maze_data[0] = 1'b1; maze_data[1] = 1'b1; maze_data[16] = 1'b1; maze_data[32] = 1'b1;
    goal_x = 4'd0; goal_y = 4'd2; start = 1'b1;
    do_step(4'd0, 4'd0, 10'd0);
    do_step(4'd1, 4'd0, 10'd1);
    do_step(4'd0, 4'd0, 10'd2);
    do_step(4'd0, 4'd1, 10'd3);
    do_step(4'd0, 4'd2, 10'd4);
    chk("de_done", 32'(done), 32'd1);
    chk("de_count", 32'(step_count), 32'd5);
    start = 1'b0;
    @(negedge clk);

    // Blocked start cell
    maze_data = ~256'h1; goal_x = 4'd3; goal_y = 4'd0; start = 1'b1;
    @(negedge clk);
    chk("bs_fail_early", 32'(fail), 32'd0);
    @(negedge clk);
    chk("bs_fail", 32'(fail), 32'd1);
    chk("bs_done", 32'(done), 32'd0);
    chk("bs_valid", 32'(s_if.step_valid), 32'd0);
    start = 1'b0;
    @(negedge clk);
    chk("bs_idle", 32'(fail), 32'd0);

    // Wall goal cell
    maze_data = 256'h1; goal_x = 4'd5; goal_y = 4'd5; start = 1'b1;
    @(negedge clk);
    chk("wg_fail_early", 32'(fail), 32'd0);
    chk("wg_valid0", 32'(s_if.step_valid), 32'd0);
    @(negedge clk);
    chk("wg_fail", 32'(fail), 32'd1);
    chk("wg_done", 32'(done), 32'd0);
    chk("wg_valid", 32'(s_if.step_valid), 32'd0);
    start = 1'b0;
    @(negedge clk);

    // Step limit: 2x2 loop, goal (5,5) open but unreachable
    maze_data = '0;
    maze_data[0] = 1'b1; maze_data[1] = 1'b1; maze_data[16] = 1'b1; maze_data[17] = 1'b1;
    maze_data[85] = 1'b1;
    goal_x = 4'd5; goal_y = 4'd5; start = 1'b1;
    do_step(4'd0, 4'd0, 10'd0);
    do_step(4'd1, 4'd0, 10'd1);
    do_step(4'd1, 4'd1, 10'd2);
    do_step(4'd0, 4'd1, 10'd3);
    do_step(4'd0, 4'd0, 10'd4);
    do_step(4'd1, 4'd0, 10'd5);
    do_step(4'd1, 4'd1, 10'd6);
    do_step(4'd0, 4'd1, 10'd7);
    chk("sl_fail", 32'(fail), 32'd1);
    chk("sl_done", 32'(done), 32'd0);
    chk("sl_count", 32'(step_count), 32'd8);
    chk("sl_valid", 32'(s_if.step_valid), 32'd0);
    start = 1'b0;
    @(negedge clk);
    chk("sl_idle_fail", 32'(fail), 32'd0);
    chk("sl_idle_count", 32'(step_count), 32'd0);

    // Asynchronous reset mid-EMIT
    maze_data = 256'hF; goal_x = 4'd3; goal_y = 4'd0; start = 1'b1;
    do_step(4'd0, 4'd0, 10'd0);
    s_if.step_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("ar_pre_valid", 32'(s_if.step_valid), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("ar_valid", 32'(s_if.step_valid), 32'd0);
    chk("ar_count", 32'(step_count), 32'd0);
    chk("ar_x", 32'(s_if.step_x), 32'd0);
    chk("ar_done", 32'(done), 32'd0);
    chk("ar_fail", 32'(fail), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    s_if.step_ready = 1'b1;
    do_step(4'd0, 4'd0, 10'd0);
    do_step(4'd1, 4'd0, 10'd1);
    do_step(4'd2, 4'd0, 10'd2);
    do_step(4'd3, 4'd0, 10'd3);
    chk("ar_re_done", 32'(done), 32'd1);
    chk("ar_re_count", 32'(step_count), 32'd4);
    start = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/maze_solver.md
Name: maze_solver

Overview:
- Reads a finished 16x16 maze bitmap, the one the maze carver produces, and walks it from (0,0) to a goal cell using the left-hand wall-follower rule.
- Streams each visited cell out over a valid/ready handshake so a downstream renderer or trace buffer can consume the path.
- Sits directly after the carver: the carver's finish drives this block's start, and the carver's maze_data drives this block's maze_data.

Parameters:
- MAZE_W, 16, maze width in cells; the design is only supported at 16.
- MAZE_H, 16, maze height in cells; the design is only supported at 16.
- MAX_STEPS, 1023, maximum number of accepted steps before the block declares failure. Range 1..1023.

Ports:
- clk  in  1  single clock; all logic on posedge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  level input; solve begins on the first posedge in IDLE where start=1.
- maze_data  in  256  maze bitmap; cell (x,y) is bit x+16*y; 1=open path, 0=wall.
- goal_x  in  4  goal column.
- goal_y  in  4  goal row.
- step_valid  out  1  step_x/step_y hold a valid path cell.
- step_ready  in  1  downstream accepts the step.
- step_x  out  4  column of the current path cell.
- step_y  out  4  row of the current path cell.
- step_count  out  10  number of accepted steps.
- done  out  1  goal reached; sticky.
- fail  out  1  solve aborted; sticky.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE.
  - All outputs are 0: step_valid, step_x, step_y, step_count, done, fail.
  - Internal state is also cleared: heading=E, probe=0.
  - This applies in any state, including mid-handshake; an in-flight step is dropped.
- States: IDLE, INIT, EMIT, PROBE, DONE, FAIL.
- IDLE:
  - On start=1, latch maze_data into an internal 256-bit snapshot and latch goal_x/goal_y.
  - Set cur=(0,0), heading=E, step_count=0; go to INIT.
  - Changes to maze_data or goal_* after the latch are ignored.
- INIT:
  - If snapshot bit 0 is 0, or the goal cell bit is 0, go to FAIL.
  - Otherwise go to EMIT with step_x/y=(0,0).
  - Net effect: fail is visible 2 cycles after start is sampled, and step_valid is never asserted.
- EMIT:
  - step_valid=1; step_x/step_y hold cur and must stay stable until a transfer.
  - Transfer = posedge with step_valid=1 and step_ready=1. On transfer, step_count increments.
  - After a transfer:
    - If cur==goal, go to DONE.
    - Else if the new step_count equals MAX_STEPS, go to FAIL.
    - Else go to PROBE with probe=0.
  - step_valid deasserts in the cycle after the transfer.
  - If step_ready is held low, the block stalls indefinitely with no other side effects.
- PROBE: one candidate direction per cycle.
  - Heading encoding: 0=N (y-1), 1=E (x+1), 2=S (y+1), 3=W (x-1).
  - Probe order is left, straight, right, back, i.e. candidate = (heading + {3,0,1,2}[probe]) mod 4, using 2-bit wrap arithmetic.
  - A candidate is open if the neighbour is inside 0..15 in both axes and its snapshot bit is 1. Out-of-bounds counts as wall; coordinates never wrap.
  - If open: cur<=neighbour, heading<=candidate, go to EMIT.
  - If not open: probe increments. A failure at probe=3 goes to FAIL (isolated cell).
  - Latency from one transfer to the next step_valid is 1 to 4 cycles.
- DONE / FAIL:
  - done=1 or fail=1, held while start=1; done and fail are never both 1.
  - step_x/y keep the last cell.
  - When start=0, return to IDLE. done, fail and step_count clear on the IDLE entry edge.
- start dropping during INIT, EMIT or PROBE is ignored; the solve runs to DONE or FAIL.
- A goal of (0,0) with an open start cell gives one step (0,0), then done.

Test Plan:
- Straight corridor: cells (0,0)..(3,0) open, all others 0, goal (3,0), step_ready=1 → steps (0,0),(1,0),(2,0),(3,0); done=1; step_count=4; fail=0.
- Dead-end backtrack: open cells (0,0),(1,0),(0,1),(0,2), goal (0,2) → steps (0,0),(1,0),(0,0),(0,1),(0,2); step_count=5; done=1.
- Backpressure: in the corridor test, hold step_ready=0 for 5 cycles on step 2 → step_valid stays 1, step_x/y stay (1,0), step_count stays 1; normal resumption afterwards.
- Blocked start: maze_data[0]=0 → fail=1 exactly 2 cycles after start is sampled; step_valid never 1; done=0. Repeat with a wall goal cell and expect the same result.
- Step limit: MAX_STEPS=8, a 2x2 open loop, goal (5,5) open but unreachable → exactly 8 transfers, then fail=1 with step_count=8. Dropping start returns to IDLE with counters cleared.
- Async reset: assert reset=0 mid-EMIT between clock edges → step_valid, done, fail and step_count go to 0 immediately. Releasing reset with start=1 begins a fresh solve from (0,0).
